chacha_ise_block_seq: RTL and testbench

//  Sequences one ChaCha block computation over a single quarter-round ISE datapath.

---
 rtl/chacha_ise_block_seq_pkg.sv | 42 ++++
 rtl/chacha_ise_block_seq_qr.sv | 41 ++++
 rtl/chacha_ise_block_seq.sv | 123 ++++++++++++
 tb/tb_chacha_ise_block_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_ise_block_seq_pkg.sv
// Shared definitions for the ChaCha block sequencer: sigma constants, the
// quarter-round index table, FSM states and a rotate helper.
package chacha_ise_block_seq_pkg;

    // "expand 32-byte k", word 0 in the low 32 bits
    localparam logic [3:0][31:0] SIGMA = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_OUT
    } fsm_state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
    } qr_idx_t;

    // Quarter-rounds 0-3 are columns, 4-7 are diagonals
    function automatic qr_idx_t qr_index(input logic [2:0] qr);
        case (qr)
            3'd0:    qr_index = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1:    qr_index = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2:    qr_index = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3:    qr_index = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4:    qr_index = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    qr_index = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    qr_index = {4'd2, 4'd7, 4'd8,  4'd13};
            default: qr_index = {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_ise_block_seq_qr.sv
// v1 quarter-round datapath: op_ad produces the new {a,d}, op_bc the new {b,c}
// given the already-updated {a,d} and the original {b,c}.
module chacha_ise_v1
    import chacha_ise_block_seq_pkg::*;
(
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
    input  logic        op_ad,
    input  logic        op_bc,
    output logic [63:0] rd
);

    logic [31:0] a, b, c, d;
    logic [31:0] a1, b1, c1, d1, a2, d2;
    logic [31:0] e_d1, e_c1, e_b1, e_c2, e_b2;

    // The bc half recovers the intermediate d from the final {a,d} by undoing the rotate-by-8
    always_comb begin
        a    = rs1[63:32];
        d    = rs1[31:0];
        b    = rs2[63:32];
        c    = rs2[31:0];
        a1   = a + b;
        d1   = rotl32(d ^ a1, 16);
        c1   = c + d1;
        b1   = rotl32(b ^ c1, 12);
        a2   = a1 + b1;
        d2   = rotl32(d1 ^ a2, 8);
        e_d1 = rotl32(d, 24) ^ a;
        e_c1 = c + e_d1;
        e_b1 = rotl32(b ^ e_c1, 12);
        e_c2 = e_c1 + d;
        e_b2 = rotl32(e_b1 ^ e_c2, 7);
        rd   = '0;
        if (op_ad)
            rd = {a2, d2};
        else if (op_bc)
            rd = {e_b2, e_c2};
    end

endmodule

// File: rtl/chacha_ise_block_seq.sv
// Runs one ChaCha block through a single quarter-round ISE datapath, two
// datapath ops per quarter-round, then feed-forward and output handshake.
module chacha_ise_block_seq
    import chacha_ise_block_seq_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_key,
    input  logic [31:0]  in_ctr,
    input  logic [95:0]  in_nonce,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_ks,
    output logic         busy
);

    localparam int STEPS = ROUNDS * 8;
    localparam int KW    = $clog2(STEPS);

    if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
        $error("chacha_ise_block_seq: ROUNDS must be 8, 12 or 20");
    end

    fsm_state_t  fsm;
    logic [KW-1:0] k;
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] load_w [16];
    qr_idx_t     idx;
    logic        phase;
    logic        op_ad, op_bc;
    logic [63:0] rs1, rs2, rd;

    assign idx   = qr_index(k[3:1]);
    assign phase = k[0];
    assign op_ad = (fsm == ST_ROUND) && !phase;
    assign op_bc = (fsm == ST_ROUND) && phase;
    assign rs1   = {s[idx.a], s[idx.d]};
    assign rs2   = {s[idx.b], s[idx.c]};

    always_comb begin
        for (int i = 0; i < 4; i++) load_w[i] = SIGMA[i];
        for (int i = 0; i < 8; i++) load_w[4+i] = in_key[32*i+:32];
        load_w[12] = in_ctr;
        for (int j = 0; j < 3; j++) load_w[13+j] = in_nonce[32*j+:32];
    end

    chacha_ise_v1 u_qr (
        .rs1   (rs1),
        .rs2   (rs2),
        .op_ad (op_ad),
        .op_bc (op_bc),
        .rd    (rd)
    );

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            fsm       <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_ks    <= '0;
            k         <= '0;
            for (int i = 0; i < 16; i++) begin
                s[i] <= '0;
                x[i] <= '0;
            end
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            s[i] <= load_w[i];
                            x[i] <= load_w[i];
                        end
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (!phase) begin
                        s[idx.a] <= rd[63:32];
                        s[idx.d] <= rd[31:0];
                    end else begin
                        s[idx.b] <= rd[63:32];
                        s[idx.c] <= rd[31:0];
                    end
                    if (k == KW'(STEPS - 1)) begin
                        k   <= '0;
                        fsm <= ST_FINAL;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_FINAL: begin
                    // Feed-forward: keystream is the permuted state plus the original input
                    for (int i = 0; i < 16; i++) begin
                        s[i]             <= s[i] + x[i];
                        out_ks[32*i+:32] <= s[i] + x[i];
                    end
                    out_valid <= 1'b1;
                    fsm       <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_ise_block_seq.sv
// Randomised scoreboard bench for chacha_ise_block_seq against a plain
// ChaCha reference model, plus RFC 8439 known-answer vectors.
module tb_chacha_ise_block_seq;

    logic         g_clk = 1'b0;
    logic         g_rst = 1'b1;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [255:0] in_key;
    logic [31:0]  in_ctr;
    logic [95:0]  in_nonce;
    logic [511:0] out_ks;

    logic         sm_valid;
    logic         in_ready8, out_valid8, busy8, in_ready12, out_valid12, busy12;
    logic [511:0] out_ks8, out_ks12;

    logic [63:0]  qr_rs1, qr_rs2, qr_rd;
    logic         qr_op_ad, qr_op_bc;

    int           nChecks = 0;
    int           nPass = 0;
    logic [511:0] expQ [$];
    logic [511:0] sbExp;

    always #5 g_clk = ~g_clk;

    chacha_ise_block_seq #(.ROUNDS(20)) dut (
        .g_clk(g_clk), .g_rst(g_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_ctr(in_ctr), .in_nonce(in_nonce), .out_valid(out_valid),
        .out_ready(out_ready), .out_ks(out_ks), .busy(busy)
    );

    chacha_ise_block_seq #(.ROUNDS(8)) dut8 (
        .g_clk(g_clk), .g_rst(g_rst), .in_valid(sm_valid), .in_ready(in_ready8),
        .in_key(in_key), .in_ctr(in_ctr), .in_nonce(in_nonce), .out_valid(out_valid8),
        .out_ready(1'b1), .out_ks(out_ks8), .busy(busy8)
    );

    chacha_ise_block_seq #(.ROUNDS(12)) dut12 (
        .g_clk(g_clk), .g_rst(g_rst), .in_valid(sm_valid), .in_ready(in_ready12),
        .in_key(in_key), .in_ctr(in_ctr), .in_nonce(in_nonce), .out_valid(out_valid12),
        .out_ready(1'b1), .out_ks(out_ks12), .busy(busy12)
    );

    chacha_ise_v1 u_qr (
        .rs1(qr_rs1), .rs2(qr_rs2), .op_ad(qr_op_ad), .op_bc(qr_op_bc), .rd(qr_rd)
    );

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] refQr(input logic [31:0] a, b, c, d);
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Textbook ChaCha block: column round then diagonal round, then add input
    function automatic logic [511:0] refBlock(input logic [255:0] key, input logic [31:0] ctr,
                                              input logic [95:0] nonce, input int rounds);
        logic [31:0]  w [16];
        logic [31:0]  init [16];
        logic [127:0] q;
        logic [511:0] ks;
        int           ia, ib, ic, id;
        init[0] = 32'h61707865; init[1] = 32'h3320646e;
        init[2] = 32'h79622d32; init[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) init[4+i] = key[32*i+:32];
        init[12] = ctr;
        for (int i = 0; i < 3; i++) init[13+i] = nonce[32*i+:32];
        for (int i = 0; i < 16; i++) w[i] = init[i];
        for (int r = 0; r < rounds / 2; r++) begin
            for (int diag = 0; diag < 2; diag++) begin
                for (int i = 0; i < 4; i++) begin
                    ia = i;
                    ib = 4 + (i + diag) % 4;
                    ic = 8 + (i + 2 * diag) % 4;
                    id = 12 + (i + 3 * diag) % 4;
                    q = refQr(w[ia], w[ib], w[ic], w[id]);
                    w[ia] = q[127:96]; w[ib] = q[95:64]; w[ic] = q[63:32]; w[id] = q[31:0];
                end
            end
        end
        for (int i = 0; i < 16; i++) ks[32*i+:32] = w[i] + init[i];
        return ks;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        nChecks++;
        if (actual === expected)
            nPass++;
        else
            $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [255:0] key, input logic [31:0] ctr,
                                 input logic [95:0] nonce, input bit expectOut);
        checkOutput("in_ready_before_load", in_ready, 1);
        in_key   = key;
        in_ctr   = ctr;
        in_nonce = nonce;
        if (expectOut)
            expQ.push_back(refBlock(key, ctr, nonce, 20));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_key   = {8{$urandom()}};
        in_ctr   = $urandom();
        in_nonce = {3{$urandom()}};
    endtask

    task automatic waitOut(input int expLat, input string name);
        int n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        checkOutput(name, n, expLat);
    endtask

    always @(negedge g_clk) begin
        if (!g_rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_block got=%0h expected=none", out_ks);
            end else begin
                sbExp = expQ.pop_front();
                checkOutput("keystream_block", out_ks, sbExp);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] rfcKey;
        logic [95:0]  rfcNonce;
        logic [31:0]  a2, d2;
        logic [511:0] hold, ks8, ks12, exp8, exp12;
        int           bad, lat8, lat12;

        in_valid = 0; out_ready = 1; sm_valid = 0;
        in_key = '0; in_ctr = '0; in_nonce = '0;
        qr_rs1 = '0; qr_rs2 = '0; qr_op_ad = 0; qr_op_bc = 0;
        for (int i = 0; i < 32; i++) rfcKey[8*i+:8] = 8'(i);
        rfcNonce = 96'h00000000_4a000000_09000000;

        repeat (3) tick();
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_ks", out_ks, 0);
        g_rst = 1'b0;

        $display("[TB] datapath pair, RFC 8439 2.1.1");
        qr_rs1 = {32'h11111111, 32'h01234567};
        qr_rs2 = {32'h01020304, 32'h9b8d6f43};
        qr_op_ad = 1; #1;
        a2 = qr_rd[63:32]; d2 = qr_rd[31:0];
        checkOutput("qr_a", a2, 32'hea2a92f4);
        checkOutput("qr_d", d2, 32'h5881c4bb);
        qr_op_ad = 0; qr_op_bc = 1; qr_rs1 = {a2, d2}; #1;
        checkOutput("qr_b", qr_rd[63:32], 32'hcb1cf8ce);
        checkOutput("qr_c", qr_rd[31:0], 32'h4581472e);
        qr_op_bc = 0; #1;
        checkOutput("qr_idle_rd", qr_rd, 0);

        $display("[TB] RFC 8439 2.3.2 block");
        applyStimulus(rfcKey, 32'd1, rfcNonce, 1);
        waitOut(161, "latency_rfc232");
        checkOutput("rfc232_word0", out_ks[31:0], 32'he4e7f110);
        tick();
        checkOutput("in_ready_after_handshake", in_ready, 1);

        $display("[TB] RFC 8439 A.1 vector 1");
        applyStimulus('0, 32'd0, '0, 1);
        waitOut(161, "latency_a1");
        checkOutput("a1_word0", out_ks[31:0], 32'hade0b876);
        tick();

        $display("[TB] backpressure");
        out_ready = 0;
        applyStimulus({8{$urandom()}}, $urandom(), {3{$urandom()}}, 1);
        waitOut(161, "latency_backpressure");
        hold = out_ks;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_key   = {8{$urandom()}};
            tick();
            if (!out_valid || out_ks !== hold || in_ready || !busy) bad++;
        end
        in_valid = 0;
        checkOutput("backpressure_hold_violations", bad, 0);
        out_ready = 1;
        tick();
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_out_valid", out_valid, 0);

        $display("[TB] reset mid-block");
        applyStimulus(rfcKey, 32'd1, rfcNonce, 0);
        repeat (37) tick();
        g_rst = 1;
        tick();
        g_rst = 0;
        checkOutput("midreset_in_ready", in_ready, 1);
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        applyStimulus(rfcKey, 32'd1, rfcNonce, 1);
        waitOut(161, "latency_after_reset");
        tick();

        $display("[TB] back-to-back");
        applyStimulus(rfcKey, 32'd1, rfcNonce, 1);
        waitOut(161, "latency_b2b_first");
        tick();
        applyStimulus(rfcKey, 32'd2, rfcNonce, 1);
        checkOutput("b2b_second_loaded", busy, 1);
        waitOut(161, "latency_b2b_second");
        tick();

        $display("[TB] random blocks");
        for (int t = 0; t < 3; t++) begin
            out_ready = 0;
            applyStimulus({8{$urandom()}}, $urandom(), {3{$urandom()}}, 1);
            waitOut(161, "latency_random");
            repeat ($urandom_range(0, 5)) tick();
            out_ready = 1;
            tick();
        end

        $display("[TB] ROUNDS=8 and ROUNDS=12");
        in_key = {8{$urandom()}}; in_ctr = $urandom(); in_nonce = {3{$urandom()}};
        exp8  = refBlock(in_key, in_ctr, in_nonce, 8);
        exp12 = refBlock(in_key, in_ctr, in_nonce, 12);
        lat8 = 0; lat12 = 0; ks8 = '0; ks12 = '0;
        sm_valid = 1;
        tick();
        sm_valid = 0;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (out_valid8 && lat8 == 0) begin lat8 = n; ks8 = out_ks8; end
            if (out_valid12 && lat12 == 0) begin lat12 = n; ks12 = out_ks12; end
        end
        checkOutput("latency_r8", lat8, 65);
        checkOutput("latency_r12", lat12, 97);
        checkOutput("block_r8", ks8, exp8);
        checkOutput("block_r12", ks12, exp12);

        repeat (5) tick();
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
